instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/ifu_pkg.sv | 7 +
 rtl/instr_fetch_unit_if.sv | 26 ++
 rtl/ifu_line_buf.sv | 32 +++
 rtl/instr_fetch_unit.sv | 108 ++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
package ifu_pkg;
    typedef enum logic [1:0] {IDLE, REFILL, FETCH} state_t;
    typedef logic [31:0] instr_t;
    localparam instr_t NOP = 32'h0000_0013;
    localparam instr_t LNOP = 32'h0000_0000;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: refill bus, redirect and decode handshake of the fetch unit.
interface instr_fetch_unit_if import ifu_pkg::*; #(
    parameter int ISSUE_W = 2,
    parameter int LINE_DEPTH = 16,
    parameter int ADDR_W = 16
);
    logic refill_req;
    logic [ADDR_W-$clog2(LINE_DEPTH)-1:0] refill_addr;
    logic refill_ack;
    instr_t [LINE_DEPTH-1:0] ins_line;
    logic redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic out_valid;
    logic out_ready;
    instr_t [ISSUE_W-1:0] instr_out;
    logic [ISSUE_W-1:0] instr_vld;
    logic [ADDR_W-1:0] out_pc;
    modport master (
        output refill_req, refill_addr, out_valid, instr_out, instr_vld, out_pc,
        input refill_ack, ins_line, redirect_valid, redirect_pc, out_ready
    );
    modport slave (
        input refill_req, refill_addr, out_valid, instr_out, instr_vld, out_pc,
        output refill_ack, ins_line, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/ifu_line_buf.sv
// ifu_line_buf: single tagged instruction line, whole-line write, aligned group read.
module ifu_line_buf import ifu_pkg::*; #(
    parameter int ISSUE_W = 2,
    parameter int LINE_DEPTH = 16,
    parameter int TAG_W = 12
) (
    input logic clk,
    input logic reset,
    input logic wr_en,
    input logic [TAG_W-1:0] wr_tag,
    input instr_t [LINE_DEPTH-1:0] wr_line,
    input logic [$clog2(LINE_DEPTH)-1:0] rd_off,
    output instr_t [ISSUE_W-1:0] rd_data,
    output logic [TAG_W-1:0] tag,
    output logic valid
);
    localparam int LW = $clog2(LINE_DEPTH);
    instr_t [LINE_DEPTH-1:0] mem;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            mem <= {LINE_DEPTH{NOP}};
            tag <= '0;
            valid <= 1'b0;
        end else if (wr_en) begin
            mem <= wr_line;
            tag <= wr_tag;
            valid <= 1'b1;
        end
    for (genvar i = 0; i < ISSUE_W; i++) begin : g_rd
        assign rd_data[i] = mem[rd_off + LW'(i)];
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: line-buffered fetch of ISSUE_W-wide groups with redirect and sequential refill.
// Optional perf counters when IFU_PERF_CNT_EN is defined.
module instr_fetch_unit import ifu_pkg::*; #(
    parameter int ISSUE_W = 2,
    parameter int LINE_DEPTH = 16,
    parameter int ADDR_W = 16
) (
    input logic clk,
    input logic reset,
    instr_fetch_unit_if.master bus
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt,
    output logic [31:0] refill_cnt
`endif
);
    localparam int LW = $clog2(LINE_DEPTH);
    localparam int TW = ADDR_W - LW;
    localparam logic [ADDR_W-1:0] LANE_M = ADDR_W'(ISSUE_W - 1);
    state_t state, state_nx;
    logic [ADDR_W-1:0] pc, pc_nx, grp_pc, seq_pc, out_pc_nx;
    logic [TW-1:0] rf_addr, rf_addr_nx, buf_tag, tgt;
    logic buf_valid, load, fill, out_valid_nx;
    instr_t [ISSUE_W-1:0] grp, lane_ins, instr_nx;
    logic [ISSUE_W-1:0] lane_vld, vld_nx;
    assign grp_pc = pc & ~LANE_M;
    assign seq_pc = grp_pc + ADDR_W'(ISSUE_W);
    assign load = state == FETCH && !bus.redirect_valid && (!bus.out_valid || bus.out_ready);
    assign fill = state == REFILL && bus.refill_ack;
    assign bus.refill_req = state == REFILL;
    assign bus.refill_addr = rf_addr;
    ifu_line_buf #(.ISSUE_W(ISSUE_W), .LINE_DEPTH(LINE_DEPTH), .TAG_W(TW)) u_buf (
        .clk(clk), .reset(reset), .wr_en(fill), .wr_tag(rf_addr), .wr_line(bus.ins_line),
        .rd_off(grp_pc[LW-1:0]), .rd_data(grp), .tag(buf_tag), .valid(buf_valid)
    );
    // lanes below the entry point of a redirected group are masked to LNOP
    for (genvar i = 0; i < ISSUE_W; i++) begin : g_lane
        assign lane_vld[i] = ADDR_W'(i) >= (pc & LANE_M);
        assign lane_ins[i] = lane_vld[i] ? grp[i] : LNOP;
    end
    always_comb begin
        state_nx = state;
        pc_nx = pc;
        rf_addr_nx = rf_addr;
        out_valid_nx = bus.out_valid & ~bus.out_ready;
        out_pc_nx = bus.out_pc;
        instr_nx = bus.instr_out;
        vld_nx = bus.instr_vld;
        if (bus.redirect_valid) begin
            pc_nx = bus.redirect_pc;
            out_valid_nx = 1'b0;
        end else if (load) begin
            pc_nx = seq_pc;
            out_valid_nx = 1'b1;
            out_pc_nx = grp_pc;
            instr_nx = lane_ins;
            vld_nx = lane_vld;
        end
        tgt = pc_nx[ADDR_W-1:LW];
        // an outstanding refill always completes before the new target line is requested
        case (state)
            IDLE: begin
                state_nx = REFILL;
                rf_addr_nx = tgt;
            end
            REFILL: if (fill) begin
                state_nx = tgt == rf_addr ? FETCH : REFILL;
                rf_addr_nx = tgt;
            end
            FETCH: if (!(buf_valid && tgt == buf_tag)) begin
                state_nx = REFILL;
                rf_addr_nx = tgt;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            pc <= '0;
            rf_addr <= '0;
            bus.out_valid <= 1'b0;
            bus.out_pc <= '0;
            bus.instr_out <= '0;
            bus.instr_vld <= '0;
        end else begin
            state <= state_nx;
            pc <= pc_nx;
            rf_addr <= rf_addr_nx;
            bus.out_valid <= out_valid_nx;
            bus.out_pc <= out_pc_nx;
            bus.instr_out <= instr_nx;
            bus.instr_vld <= vld_nx;
        end
`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
            refill_cnt <= '0;
        end else begin
            fetch_cnt <= fetch_cnt + 32'(bus.out_valid && bus.out_ready);
            stall_cnt <= stall_cnt + 32'(bus.out_valid && !bus.out_ready);
            refill_cnt <= refill_cnt + 32'(fill);
        end
`endif
endmodule
